vector_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the six-lane vector ALU array in the execute stage.
- LANES × N-bit lanes with per-lane operand select (vector, broadcast lane, immediate) and a lane-enable mask.
- Optional cross-lane sum reduction; registered 2-stage datapath with valid, stall and flush.
- Output feeds the vector writeback stage.

---
 rtl/vector_alu_pkg.sv | 27 ++
 rtl/vector_alu_pipe_if.sv | 42 ++++
 rtl/vector_alu_lane.sv | 45 ++++
 rtl/vector_alu_pipe.sv | 149 ++++++++++++++
 tb/tb_vector_alu_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_alu_pkg.sv
// Shared types and constants for the pipelined vector ALU.
package vector_alu_pkg;

    // Lane operation codes, matching the ALUControlE encoding.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    // Operand B source; the unused code 2'b11 behaves like BSEL_VEC.
    typedef enum logic [1:0] {
        BSEL_VEC   = 2'b00,
        BSEL_BCAST = 2'b01,
        BSEL_IMM   = 2'b10
    } bsel_e;

    // Bit positions inside each lane's 2-bit flag field.
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/vector_alu_pipe_if.sv
// Operand/result bundle between the execute stage and the vector ALU pipe.
//
// Handshake: in_valid qualifies every E-stage field in the cycle it is high
// and the op is taken whenever stall is low (there is no ready; the producer
// owns backpressure through stall). stall freezes the whole pipe, flush
// discards everything in flight. out_valid is high for the cycle(s) in which
// the W-stage fields hold a result that has not been seen before a non-stalled
// edge; during a stall it simply holds.
interface vector_alu_pipe_if #(
    parameter int N     = 8,
    parameter int LANES = 6,
    parameter int IDXW  = $clog2(LANES)
);
    logic                       in_valid;
    logic                       stall;
    logic                       flush;
    logic [LANES-1:0][N-1:0]    SrcAE;
    logic [LANES-1:0][N-1:0]    SrcBE;
    logic [IDXW-1:0]            SrcBiE;
    logic [N-1:0]               ImmE;
    logic [2:0]                 ALUControlE;
    logic [1:0]                 VSIFlagE;
    logic [LANES-1:0]           LaneMaskE;
    logic                       RedE;

    logic                       out_valid;
    logic [LANES-1:0][N-1:0]    ALUOutputW;
    logic [LANES-1:0][1:0]      ALUFlagsW;
    logic                       AllZeroW;

    modport master (
        output in_valid, stall, flush, SrcAE, SrcBE, SrcBiE, ImmE,
               ALUControlE, VSIFlagE, LaneMaskE, RedE,
        input  out_valid, ALUOutputW, ALUFlagsW, AllZeroW
    );

    modport slave (
        input  in_valid, stall, flush, SrcAE, SrcBE, SrcBiE, ImmE,
               ALUControlE, VSIFlagE, LaneMaskE, RedE,
        output out_valid, ALUOutputW, ALUFlagsW, AllZeroW
    );
endinterface

// File: rtl/vector_alu_lane.sv
// One combinational N-bit ALU lane with an enable mask and {Neg, Zero} flags.
module vector_alu_lane
    import vector_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_e      op,
    input  logic         en,
    output logic [N-1:0] result,
    output logic [1:0]   flags
);

    logic [N-1:0] raw;

    // Raw operation; shifts by an amount >= N naturally yield 0 because the
    // full unsigned value of b is used as the shift count.
    always_comb begin
        raw = '0;
        case (op)
            ALU_ADD: raw = a + b;
            ALU_SUB: raw = a - b;
            ALU_AND: raw = a & b;
            ALU_OR:  raw = a | b;
            ALU_XOR: raw = a ^ b;
            ALU_SLL: raw = a << b;
            ALU_SRL: raw = a >> b;
            ALU_MUL: raw = a * b;
            default: raw = '0;
        endcase
    end

    // Masked lanes report a zero result with both flags clear (Zero too).
    always_comb begin
        result = '0;
        flags  = '0;
        if (en) begin
            result           = raw;
            flags[FLAG_NEG]  = raw[N-1];
            flags[FLAG_ZERO] = (raw == '0);
        end
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage vector ALU: lane ALUs feed S1, reduction/AllZero feed the W regs.
module vector_alu_pipe #(
    parameter int N     = 8,
    parameter int LANES = 6,
    parameter int IDXW  = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              reset,
    vector_alu_pipe_if.slave  bus
);
    import vector_alu_pkg::*;

    logic [N-1:0]               bcast_val;
    logic [LANES-1:0][N-1:0]    opb;
    logic [LANES-1:0][N-1:0]    lane_res;
    logic [LANES-1:0][1:0]      lane_flags;

    logic                       s1_valid;
    logic [LANES-1:0][N-1:0]    s1_res;
    logic [LANES-1:0][1:0]      s1_flags;
    logic [LANES-1:0]           s1_mask;
    logic                       s1_red;

    logic [N-1:0]               red_sum;
    logic                       norm_all_zero;
    logic [LANES-1:0][N-1:0]    s2_res;
    logic [LANES-1:0][1:0]      s2_flags;
    logic                       s2_all_zero;

    logic                       out_valid_q;
    logic [LANES-1:0][N-1:0]    out_res_q;
    logic [LANES-1:0][1:0]      out_flags_q;
    logic                       all_zero_q;

    logic                       s1_load;
    logic                       s2_load;

    // Data registers only move when a valid op advances, so bubbles and
    // flushes leave the last result parked on the outputs.
    assign s1_load = !bus.flush && !bus.stall && bus.in_valid;
    assign s2_load = !bus.flush && !bus.stall && s1_valid;

    // Broadcast operand; an index past the last lane selects zero.
    always_comb begin
        bcast_val = '0;
        if (int'(bus.SrcBiE) < LANES) begin
            bcast_val = bus.SrcBE[bus.SrcBiE];
        end
    end

    // Per-lane operand B select.
    always_comb begin
        opb = '0;
        for (int i = 0; i < LANES; i++) begin
            case (bus.VSIFlagE)
                BSEL_BCAST: opb[i] = bcast_val;
                BSEL_IMM:   opb[i] = bus.ImmE;
                default:    opb[i] = bus.SrcBE[i];
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vector_alu_lane #(.N(N)) u_lane (
            .a      (bus.SrcAE[g]),
            .b      (opb[g]),
            .op     (alu_op_e'(bus.ALUControlE)),
            .en     (bus.LaneMaskE[g]),
            .result (lane_res[g]),
            .flags  (lane_flags[g])
        );
    end

    // S1: lane results plus the mask and reduce request they belong to.
    // Flush beats stall; reset beats both.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_flags <= '0;
            s1_mask  <= '0;
            s1_red   <= 1'b0;
        end else begin
            if (bus.flush) begin
                s1_valid <= 1'b0;
            end else if (!bus.stall) begin
                s1_valid <= bus.in_valid;
            end
            if (s1_load) begin
                s1_res   <= lane_res;
                s1_flags <= lane_flags;
                s1_mask  <= bus.LaneMaskE;
                s1_red   <= bus.RedE;
            end
        end
    end

    // Reduction sum (wraps mod 2^N) and the AllZero summary for S2.
    always_comb begin
        red_sum       = '0;
        norm_all_zero = 1'b1;
        s2_res        = '0;
        s2_flags      = '0;
        s2_all_zero   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_mask[i]) begin
                red_sum       = red_sum + s1_res[i];
                norm_all_zero = norm_all_zero & s1_flags[i][FLAG_ZERO];
            end
        end
        if (s1_red) begin
            s2_res[0]             = red_sum;
            s2_flags[0][FLAG_NEG] = red_sum[N-1];
            s2_flags[0][FLAG_ZERO] = (red_sum == '0);
            s2_all_zero           = (|s1_mask) && (red_sum == '0);
        end else begin
            s2_res      = s1_res;
            s2_flags    = s1_flags;
            s2_all_zero = (|s1_mask) && norm_all_zero;
        end
    end

    // S2 / W-stage output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
            all_zero_q  <= 1'b0;
        end else begin
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (!bus.stall) begin
                out_valid_q <= s1_valid;
            end
            if (s2_load) begin
                out_res_q   <= s2_res;
                out_flags_q <= s2_flags;
                all_zero_q  <= s2_all_zero;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.ALUOutputW = out_res_q;
    assign bus.ALUFlagsW  = out_flags_q;
    assign bus.AllZeroW   = all_zero_q;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe (N = 8, LANES = 6).
module tb_vector_alu_pipe;

    localparam int N     = 8;
    localparam int LANES = 6;
    localparam int IDXW  = 3;
    localparam int W     = LANES*N + LANES*2 + 1;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  vsi;
        logic [2:0]  bi;
        logic [7:0]  imm;
        logic [5:0]  mask;
        logic        red;
        logic [47:0] a;
        logic [47:0] b;
    } in_t;

    typedef struct {
        logic [47:0] res;
        logic [11:0] flags;
        logic        allzero;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] exp_q[$];
    vec_t         tbl[13];

    vector_alu_pipe_if #(.N(N), .LANES(LANES), .IDXW(IDXW)) bus ();

    vector_alu_pipe #(.N(N), .LANES(LANES), .IDXW(IDXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] vsi,
                                input logic [2:0] bi, input logic [7:0] imm,
                                input logic [5:0] mask, input logic red,
                                input logic [47:0] a, input logic [47:0] b,
                                input logic [47:0] res, input logic [11:0] flags,
                                input logic az);
        vec_t v;
        v.i.op = op; v.i.vsi = vsi; v.i.bi = bi; v.i.imm = imm;
        v.i.mask = mask; v.i.red = red; v.i.a = a; v.i.b = b;
        v.e.res = res; v.e.flags = flags; v.e.allzero = az;
        return v;
    endfunction

    function automatic logic [W-1:0] pk(input out_t o);
        return {o.res, o.flags, o.allzero};
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {bus.ALUOutputW, bus.ALUFlagsW, bus.AllZeroW};
    endfunction

    // Reference model: straight from the op table with integer arithmetic.
    function automatic out_t model(input in_t v);
        out_t o;
        int   r[LANES];
        int   av, bv, s, bix;
        logic allz;
        o.res = '0; o.flags = '0; o.allzero = 1'b0;
        bix = int'(v.bi);
        for (int i = 0; i < LANES; i++) begin
            av = int'(v.a[i*8 +: 8]);
            case (v.vsi)
                2'b01:   bv = (bix < LANES) ? int'(v.b[bix*8 +: 8]) : 0;
                2'b10:   bv = int'(v.imm);
                default: bv = int'(v.b[i*8 +: 8]);
            endcase
            case (v.op)
                3'd0:    r[i] = av + bv;
                3'd1:    r[i] = av - bv;
                3'd2:    r[i] = av & bv;
                3'd3:    r[i] = av | bv;
                3'd4:    r[i] = av ^ bv;
                3'd5:    r[i] = (bv >= 8) ? 0 : (av << bv);
                3'd6:    r[i] = (bv >= 8) ? 0 : (av >> bv);
                default: r[i] = av * bv;
            endcase
            r[i] = r[i] & 255;
            if (!v.mask[i]) r[i] = 0;
        end
        if (v.red) begin
            s = 0;
            for (int i = 0; i < LANES; i++) if (v.mask[i]) s = s + r[i];
            s = s & 255;
            o.res[7:0]   = 8'(s);
            o.flags[1:0] = {s >= 128, s == 0};
            o.allzero    = (v.mask != 0) && (s == 0);
        end else begin
            allz = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                o.res[i*8 +: 8] = 8'(r[i]);
                if (v.mask[i]) begin
                    o.flags[i*2 +: 2] = {r[i] >= 128, r[i] == 0};
                    if (r[i] != 0) allz = 1'b0;
                end
            end
            o.allzero = (v.mask != 0) && allz;
        end
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input in_t v, input logic valid);
        bus.in_valid    = valid;
        bus.ALUControlE = v.op;
        bus.VSIFlagE    = v.vsi;
        bus.SrcBiE      = v.bi;
        bus.ImmE        = v.imm;
        bus.LaneMaskE   = v.mask;
        bus.RedE        = v.red;
        bus.SrcAE       = v.a;
        bus.SrcBE       = v.b;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input out_t e);
        check({tag, "_valid"},   64'(bus.out_valid), 64'(1'b1));
        check({tag, "_res"},     64'(bus.ALUOutputW), 64'(e.res));
        check({tag, "_flags"},   64'(bus.ALUFlagsW), 64'(e.flags));
        check({tag, "_allzero"}, 64'(bus.AllZeroW), 64'(e.allzero));
    endtask

    // Issue one op, then a bubble; result is visible two edges after issue.
    task automatic apply_check(input string tag, input vec_t v);
        drive(v.i, 1'b1);
        @(negedge clk);
        idle();
        @(negedge clk);
        check_out(tag, v.e);
    endtask

    // ---------------- test ----------------
    initial begin
        in_t  rv;
        in_t  rst_in;
        out_t held;
        logic [W-1:0] e;
        logic [W-1:0] held_exp;
        logic held_valid;
        logic iv, st, fl, exp_v;

        tbl[0]  = mk(3'd0, 2'b00, 3'd0, 8'h00, 6'h3F, 1'b0, 48'h33291F150B01, 48'h050403020100, 48'h382D22170C01, 12'h000, 1'b0);
        tbl[1]  = mk(3'd1, 2'b00, 3'd0, 8'h00, 6'h3F, 1'b0, 48'h404040404040, 48'h404040404040, 48'h000000000000, 12'h555, 1'b1);
        tbl[2]  = mk(3'd5, 2'b01, 3'd4, 8'h00, 6'h3F, 1'b0, 48'h818181818181, 48'h070307070707, 48'h080808080808, 12'h000, 1'b0);
        tbl[3]  = mk(3'd5, 2'b01, 3'd7, 8'h00, 6'h3F, 1'b0, 48'h818181818181, 48'h070307070707, 48'h818181818181, 12'hAAA, 1'b0);
        tbl[4]  = mk(3'd1, 2'b10, 3'd0, 8'h01, 6'h03, 1'b0, 48'h000000000000, 48'h050505050505, 48'h00000000FFFF, 12'h00A, 1'b0);
        tbl[5]  = mk(3'd0, 2'b00, 3'd0, 8'h00, 6'h3F, 1'b1, 48'h646464646464, 48'h000000000000, 48'h000000000058, 12'h000, 1'b0);
        tbl[6]  = mk(3'd0, 2'b00, 3'd0, 8'h00, 6'h01, 1'b1, 48'h646464646464, 48'h000000000000, 48'h000000000064, 12'h000, 1'b0);
        tbl[7]  = mk(3'd6, 2'b00, 3'd0, 8'h00, 6'h3F, 1'b0, 48'h808080808080, 48'hC80908070100, 48'h000000014080, 12'h542, 1'b0);
        tbl[8]  = mk(3'd0, 2'b00, 3'd0, 8'h00, 6'h00, 1'b0, 48'h050505050505, 48'h010101010101, 48'h000000000000, 12'h000, 1'b0);
        tbl[9]  = mk(3'd7, 2'b00, 3'd0, 8'h00, 6'h3F, 1'b0, 48'h101010101010, 48'h111111111111, 48'h101010101010, 12'h000, 1'b0);
        tbl[10] = mk(3'd0, 2'b00, 3'd0, 8'h00, 6'h03, 1'b1, 48'h808080808080, 48'h000000000000, 48'h000000000000, 12'h001, 1'b1);
        tbl[11] = mk(3'd4, 2'b00, 3'd0, 8'h00, 6'h3F, 1'b0, 48'hF0F0F0F0F0F0, 48'h0FF00FF00FF0, 48'hFF00FF00FF00, 12'h999, 1'b0);
        tbl[12] = mk(3'd0, 2'b11, 3'd0, 8'h77, 6'h3F, 1'b0, 48'h010101010101, 48'h050403020100, 48'h060504030201, 12'h000, 1'b0);

        // Reset with a valid op on the inputs the whole time.
        rst_in = tbl[0].i;
        rst_in.a = 48'hFFFFFFFFFFFF;
        rst_in.b = 48'h0;
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(rst_in, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset_valid", 64'(bus.out_valid), 64'(0));
            check("reset_res",   64'(bus.ALUOutputW), 64'(0));
            check("reset_flags", 64'(bus.ALUFlagsW), 64'(0));
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_valid", 64'(bus.out_valid), 64'(0));
        check("post_reset_res",   64'(bus.ALUOutputW), 64'(0));
        check("post_reset_flags", 64'(bus.ALUFlagsW), 64'(0));
        idle();
        @(negedge clk);
        check("post_reset_latency_valid", 64'(bus.out_valid), 64'(1));
        check("post_reset_latency_res",   64'(bus.ALUOutputW), 64'(48'hFFFFFFFFFFFF));
        check("post_reset_latency_flags", 64'(bus.ALUFlagsW), 64'(12'hAAA));
        @(negedge clk);

        // Table-driven directed vectors.
        for (int k = 0; k < 13; k++) begin
            apply_check($sformatf("tbl%0d", k), tbl[k]);
        end

        // Stall: issue at t, stall t+1..t+2, result appears at t+4.
        apply_check("pre_stall", tbl[9]);
        drive(tbl[0].i, 1'b1);
        @(negedge clk);
        check("stall_bubble_valid", 64'(bus.out_valid), 64'(0));
        check("stall_bubble_hold",  64'(bus.ALUOutputW), 64'(tbl[9].e.res));
        idle();
        bus.stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(tbl[1].i, 1'b1);
            @(negedge clk);
            check("stall_valid", 64'(bus.out_valid), 64'(0));
            check("stall_hold",  64'(bus.ALUOutputW), 64'(tbl[9].e.res));
        end
        idle();
        bus.stall = 1'b0;
        @(negedge clk);
        check_out("stall_emerge", tbl[0].e);
        @(negedge clk);
        check("stall_after_valid", 64'(bus.out_valid), 64'(0));
        check("stall_after_hold",  64'(bus.ALUOutputW), 64'(tbl[0].e.res));

        // Flush together with stall kills the op sitting in S1.
        drive(tbl[1].i, 1'b1);
        @(negedge clk);
        idle();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_valid0", 64'(bus.out_valid), 64'(0));
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_valid1", 64'(bus.out_valid), 64'(0));
        check("flush_data_hold", 64'(bus.ALUOutputW), 64'(tbl[0].e.res));
        drive(tbl[2].i, 1'b1);
        @(negedge clk);
        idle();
        check("flush_next_early", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check_out("flush_next", tbl[2].e);

        // Back-to-back ADD, XOR, MUL.
        drive(tbl[0].i, 1'b1);
        @(negedge clk);
        drive(tbl[11].i, 1'b1);
        @(negedge clk);
        check_out("b2b_add", tbl[0].e);
        drive(tbl[9].i, 1'b1);
        @(negedge clk);
        check_out("b2b_xor", tbl[11].e);
        idle();
        @(negedge clk);
        check_out("b2b_mul", tbl[9].e);
        @(negedge clk);
        check("b2b_end_valid", 64'(bus.out_valid), 64'(0));

        // Random traffic against the model, with an in-order scoreboard.
        exp_q.delete();
        held_valid = 1'b0;
        held_exp   = '0;
        for (int k = 0; k < 420; k++) begin
            rv.op   = 3'($urandom_range(0, 7));
            rv.vsi  = 2'($urandom_range(0, 3));
            rv.bi   = 3'($urandom_range(0, 7));
            rv.imm  = 8'($urandom_range(0, 255));
            rv.mask = 6'($urandom_range(0, 63));
            rv.red  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < LANES; i++) begin
                rv.a[i*8 +: 8] = 8'($urandom_range(0, 255));
                rv.b[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12))
                                                              : 8'($urandom_range(0, 255));
            end
            if (k >= 400) begin
                iv = 1'b0; st = 1'b0; fl = 1'b0;
            end else begin
                iv = ($urandom_range(0, 9) < 7);
                st = ($urandom_range(0, 9) < 2);
                fl = ($urandom_range(0, 19) == 0);
            end
            drive(rv, iv);
            bus.stall = st;
            bus.flush = fl;
            @(negedge clk);
            if (fl) begin
                exp_q.delete();
                check("rnd_flush_valid", 64'(bus.out_valid), 64'(0));
                held_valid = 1'b0;
            end else if (st) begin
                check("rnd_stall_valid", 64'(bus.out_valid), 64'(held_valid));
                if (held_valid) check("rnd_stall_data", 64'(dut_out()), 64'(held_exp));
            end else begin
                exp_v = (exp_q.size() > 0);
                check("rnd_valid", 64'(bus.out_valid), 64'(exp_v));
                if (exp_v) begin
                    e = exp_q.pop_front();
                    check("rnd_data", 64'(dut_out()), 64'(e));
                    held_exp = e;
                end
                held_valid = exp_v;
            end
            if (!fl && !st && iv) begin
                held = model(rv);
                exp_q.push_back(pk(held));
            end
        end
        idle();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        check("rnd_drain_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
